// File: rtl/proc_pkg.sv
// proc_pkg: shared constants and types for the unified-memory port arbiter.
//   DATA_W / ADDR_W : memory word width and word-address width
//   owner_t         : which requester owns the current memory access
//   arb_state_t     : arbiter FSM states
//   mem_cmd_t       : captured memory command (write flag, address, data)
package proc_pkg;

    localparam int DATA_W = 17;
    localparam int ADDR_W = 8;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   req[0]     : CPU request
//   req[1]     : HOST request
//   last_owner : requester that was granted most recently
//   winner     : requester selected this cycle (meaningful only when any_req)
//   any_req    : at least one request is pending
module rr_arb2
    import proc_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output owner_t     winner,
    output logic       any_req
);

    always_comb begin
        any_req = |req;
        winner  = OWN_CPU;
        if (req == 2'b11)
            // contention: whoever did not go last wins, so grants alternate
            winner = (last_owner == OWN_CPU) ? OWN_HOST : OWN_CPU;
        else if (req[1])
            winner = OWN_HOST;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port instruction/data memory between
// the CPU and the program-loader/debug HOST.
//   clk, reset                       : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata            : CPU command, held until cpu_gnt
//   cpu_gnt, cpu_rvalid, cpu_rdata   : CPU issue pulse, read-return pulse, read data
//   host_*                           : same set for HOST
//   mem_en/we/addr/wdata, mem_rdata  : memory macro port (rdata MEM_LAT cycles after mem_en)
//   busy                             : FSM is not in IDLE
// Requests are only sampled in IDLE; one access is in flight at a time.
module mem_port_arbiter
    import proc_pkg::*;
#(
    parameter int DATA_W  = proc_pkg::DATA_W,
    parameter int ADDR_W  = proc_pkg::ADDR_W,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = 2;

    arb_state_t       state;
    owner_t           owner, last_owner, winner;
    logic             any_req;
    logic [CNT_W-1:0] cnt;
    logic             rsp;
    logic             sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_rr (
        .req       ({host_req, cpu_req}),
        .last_owner(last_owner),
        .winner    (winner),
        .any_req   (any_req)
    );

    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (winner == OWN_HOST) begin
            sel_we    = host_we;
            sel_addr  = host_addr;
            sel_wdata = host_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_owner <= OWN_HOST;
            cnt        <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_gnt    <= 1'b0;
            host_gnt   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= winner;
                        mem_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        // strobes are registered so they line up with ISSUE
                        mem_en    <= 1'b1;
                        cpu_gnt   <= (winner == OWN_CPU);
                        host_gnt  <= (winner == OWN_HOST);
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en     <= 1'b0;
                    mem_we     <= 1'b0;
                    cpu_gnt    <= 1'b0;
                    host_gnt   <= 1'b0;
                    last_owner <= owner;
                    if (mem_we) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= CNT_W'(MEM_LAT - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // read return; gated by reset so an aborted read never reports data
    assign rsp         = (state == WAIT) && (cnt == '0) && !reset;
    assign cpu_rvalid  = rsp && (owner == OWN_CPU);
    assign host_rvalid = rsp && (owner == OWN_HOST);
    assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
    assign host_rdata  = host_rvalid ? mem_rdata : '0;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances with MEM_LAT 1..3;
// index 1 (MEM_LAT=2) carries the functional tests, all three the latency sweep.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        cpu_req[3], cpu_we[3], cpu_gnt[3], cpu_rvalid[3];
    logic [7:0]  cpu_addr[3];
    logic [16:0] cpu_wdata[3], cpu_rdata[3];
    logic        host_req[3], host_we[3], host_gnt[3], host_rvalid[3];
    logic [7:0]  host_addr[3];
    logic [16:0] host_wdata[3], host_rdata[3];
    logic        mem_en[3], mem_we[3], busy[3];
    logic [7:0]  mem_addr[3];
    logic [16:0] mem_wdata[3], mem_rdata[3];

    int n_chk = 0;
    int n_pass = 0;

    // ROM contents seen by the bench memory model
    function automatic logic [16:0] memf(input logic [7:0] a);
        return (a == 8'h05) ? 17'h00F0F : {1'b1, a, a};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [16:0] pipe [3];
        mem_port_arbiter #(.DATA_W(17), .ADDR_W(8), .MEM_LAT(g + 1)) u_dut (
            .clk(clk), .reset(reset),
            .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
            .cpu_wdata(cpu_wdata[g]), .cpu_gnt(cpu_gnt[g]),
            .cpu_rvalid(cpu_rvalid[g]), .cpu_rdata(cpu_rdata[g]),
            .host_req(host_req[g]), .host_we(host_we[g]), .host_addr(host_addr[g]),
            .host_wdata(host_wdata[g]), .host_gnt(host_gnt[g]),
            .host_rvalid(host_rvalid[g]), .host_rdata(host_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );
        always @(posedge clk) begin
            if (reset) begin
                pipe[0] <= '0; pipe[1] <= '0; pipe[2] <= '0;
            end else begin
                pipe[0] <= (mem_en[g] && !mem_we[g]) ? memf(mem_addr[g]) : '0;
                pipe[1] <= pipe[0];
                pipe[2] <= pipe[1];
            end
        end
        assign mem_rdata[g] = pipe[g];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    int seq[4];
    int ng, dbl, nrv, bad_en, en_cyc, idx, crv;
    logic pending, gseen;
    logic [7:0] sw_addr[3];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            cpu_req[i] = 0; cpu_we[i] = 0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
            host_req[i] = 0; host_we[i] = 0; host_addr[i] = '0; host_wdata[i] = '0;
        end
        sw_addr[0] = 8'h01; sw_addr[1] = 8'h80; sw_addr[2] = 8'hFF;

        // reset state
        repeat (3) tick();
        samp();
        chk("rst_cpu_gnt",  32'(cpu_gnt[1]), 0);
        chk("rst_host_gnt", 32'(host_gnt[1]), 0);
        chk("rst_rvalid",   32'(cpu_rvalid[1] | host_rvalid[1]), 0);
        chk("rst_mem_en",   32'(mem_en[1]), 0);
        chk("rst_mem_we",   32'(mem_we[1]), 0);
        chk("rst_busy",     32'(busy[1]), 0);
        chk("rst_mem_addr", 32'(mem_addr[1]), 0);
        chk("rst_mem_wdata", 32'(mem_wdata[1]), 0);
        tick(); reset = 0;
        samp();
        chk("post_rst_busy", 32'(busy[1]), 0);

        // single CPU write
        tick();
        cpu_req[1] = 1; cpu_we[1] = 1; cpu_addr[1] = 8'h12; cpu_wdata[1] = 17'h1ABCD;
        samp();
        chk("wr_n_gnt", 32'(cpu_gnt[1]), 0);
        tick(); cpu_req[1] = 0;
        samp();
        chk("wr_en",    32'(mem_en[1]), 1);
        chk("wr_we",    32'(mem_we[1]), 1);
        chk("wr_addr",  32'(mem_addr[1]), 32'h12);
        chk("wr_wdata", 32'(mem_wdata[1]), 32'h1ABCD);
        chk("wr_gnt",   32'(cpu_gnt[1]), 1);
        chk("wr_hgnt",  32'(host_gnt[1]), 0);
        tick();
        samp();
        chk("wr_idle_busy", 32'(busy[1]), 0);
        chk("wr_idle_en",   32'(mem_en[1]), 0);
        chk("wr_idle_we",   32'(mem_we[1]), 0);

        // single HOST read, MEM_LAT=2
        tick();
        cpu_we[1] = 0;
        host_req[1] = 1; host_we[1] = 0; host_addr[1] = 8'h05;
        samp();
        tick(); host_req[1] = 0;
        samp();
        chk("rd_hgnt", 32'(host_gnt[1]), 1);
        chk("rd_en",   32'(mem_en[1]), 1);
        chk("rd_we",   32'(mem_we[1]), 0);
        chk("rd_cgnt", 32'(cpu_gnt[1]), 0);
        tick();
        samp();
        chk("rd_w1_rv",  32'(host_rvalid[1]), 0);
        chk("rd_w1_en",  32'(mem_en[1]), 0);
        chk("rd_w1_busy", 32'(busy[1]), 1);
        tick();
        samp();
        chk("rd_rvalid", 32'(host_rvalid[1]), 1);
        chk("rd_rdata",  32'(host_rdata[1]), 32'h00F0F);
        chk("rd_crv",    32'(cpu_rvalid[1]), 0);
        chk("rd_crdata", 32'(cpu_rdata[1]), 0);
        tick();
        samp();
        chk("rd_done_rv",    32'(host_rvalid[1]), 0);
        chk("rd_done_rdata", 32'(host_rdata[1]), 0);
        chk("rd_done_busy",  32'(busy[1]), 0);

        // contention from reset: both hold write requests
        tick(); reset = 1;
        tick(); tick();
        reset = 0;
        cpu_req[1] = 1; cpu_we[1] = 1; cpu_addr[1] = 8'h30;
        host_req[1] = 1; host_we[1] = 1; host_addr[1] = 8'h40;
        for (int i = 0; i < 4; i++) seq[i] = 3;
        ng = 0; dbl = 0;
        for (int c = 0; c < 30 && ng < 4; c++) begin
            samp();
            if (cpu_gnt[1] && host_gnt[1]) dbl++;
            else if (cpu_gnt[1]) begin seq[ng] = 0; ng++; end
            else if (host_gnt[1]) begin seq[ng] = 1; ng++; end
            tick();
        end
        cpu_req[1] = 0; host_req[1] = 0; cpu_we[1] = 0; host_we[1] = 0;
        chk("cont_ngrants", 32'(ng), 4);
        chk("cont_dbl",     32'(dbl), 0);
        chk("cont_g0", 32'(seq[0]), 0);
        chk("cont_g1", 32'(seq[1]), 1);
        chk("cont_g2", 32'(seq[2]), 0);
        chk("cont_g3", 32'(seq[3]), 1);
        repeat (4) tick();

        // reset during WAIT of a CPU read
        cpu_req[1] = 1; cpu_we[1] = 0; cpu_addr[1] = 8'h20;
        samp();
        tick(); cpu_req[1] = 0;
        samp();
        chk("rw_gnt", 32'(cpu_gnt[1]), 1);
        tick();
        samp();
        chk("rw_busy", 32'(busy[1]), 1);
        tick(); reset = 1;
        samp();
        chk("rw_no_rv",    32'(cpu_rvalid[1]), 0);
        chk("rw_no_rdata", 32'(cpu_rdata[1]), 0);
        tick(); reset = 0;
        host_req[1] = 1; host_we[1] = 0; host_addr[1] = 8'h05;
        samp();
        chk("rw_idle", 32'(busy[1]), 0);
        crv = 32'(cpu_rvalid[1]);
        tick(); host_req[1] = 0;
        samp();
        chk("rw_hgnt", 32'(host_gnt[1]), 1);
        chk("rw_hen",  32'(mem_en[1]), 1);
        for (int c = 0; c < 3; c++) begin
            tick(); samp();
            crv += 32'(cpu_rvalid[1]);
        end
        chk("rw_cpu_rv_total", 32'(crv), 0);

        // latency sweep, back-to-back CPU reads on each instance
        for (int k = 0; k < 3; k++) begin
            tick();
            cpu_req[k] = 1; cpu_we[k] = 0; cpu_addr[k] = sw_addr[0];
            idx = 0; nrv = 0; bad_en = 0; pending = 0; en_cyc = 0;
            for (int c = 0; c < 60 && nrv < 3; c++) begin
                samp();
                gseen = cpu_gnt[k];
                if (mem_en[k]) begin
                    if (pending) bad_en++;
                    pending = 1; en_cyc = c;
                end
                if (cpu_rvalid[k]) begin
                    if (!pending) bad_en++;
                    chk($sformatf("sw%0d_lat%0d", k + 1, nrv), 32'(c - en_cyc), 32'(k + 1));
                    chk($sformatf("sw%0d_rdata%0d", k + 1, nrv), 32'(cpu_rdata[k]),
                        32'(memf(sw_addr[nrv])));
                    pending = 0; nrv++;
                end
                tick();
                if (gseen) begin
                    idx++;
                    if (idx < 3) cpu_addr[k] = sw_addr[idx];
                    else cpu_req[k] = 0;
                end
            end
            cpu_req[k] = 0;
            chk($sformatf("sw%0d_nrv", k + 1), 32'(nrv), 3);
            chk($sformatf("sw%0d_en_in_wait", k + 1), 32'(bad_en), 0);
            repeat (3) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
